// File: rtl/tile_mem_arbiter.sv
// tile_mem_arbiter: shares the single-port tile memory between the map
// pixel renderer (r0), the ladder/prop renderer (r1) and the collision
// checker (r2). One registered access per cycle; the returned tile bit is
// routed back to the owner of that access after a fixed latency.
//
// Handshake: each rN_req is a level held until granted. rN_gnt is
// combinational and high for exactly the cycle in which the request is
// accepted; a request still high after its grant counts as a new request.
// rN_valid is a one-cycle pulse, 1+MEM_LAT cycles after the grant, with
// rN_data carrying the tile bit. rN_data keeps its last value otherwise.
module tile_mem_arbiter #(
  parameter int COORD_W    = 10,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 63
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               video_on,
  input  logic               r0_req,
  input  logic [COORD_W-1:0] r0_x,
  input  logic [COORD_W-1:0] r0_y,
  output logic               r0_gnt,
  output logic               r0_valid,
  output logic               r0_data,
  input  logic               r1_req,
  input  logic [COORD_W-1:0] r1_x,
  input  logic [COORD_W-1:0] r1_y,
  output logic               r1_gnt,
  output logic               r1_valid,
  output logic               r1_data,
  input  logic               r2_req,
  input  logic [COORD_W-1:0] r2_x,
  input  logic [COORD_W-1:0] r2_y,
  output logic               r2_gnt,
  output logic               r2_valid,
  output logic               r2_data,
  output logic               mem_en,
  output logic [COORD_W-1:0] mem_x,
  output logic [COORD_W-1:0] mem_y,
  input  logic               mem_data,
  output logic               r2_starved
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  // Owner tag carried alongside each memory access.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_R0   = 2'd1,
    TAG_R1   = 2'd2,
    TAG_R2   = 2'd3
  } tag_e;

  // Which blanking requester wins a tie between r1 and r2.
  typedef enum logic {
    RR_R1 = 1'b0,
    RR_R2 = 1'b1
  } rr_e;

  rr_e                         rr_q, rr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        starved_q, starved_d;
  logic                        mem_en_q, mem_en_d;
  logic [COORD_W-1:0]          mem_x_q, mem_x_d;
  logic [COORD_W-1:0]          mem_y_q, mem_y_d;
  tag_e                        tag_q, tag_d;
  logic [MEM_LAT-1:0][1:0]     tag_pipe_q, tag_pipe_d;
  logic                        r0_hold_q, r0_hold_d;
  logic                        r1_hold_q, r1_hold_d;
  logic                        r2_hold_q, r2_hold_d;
  logic                        starve_hit;
  logic [1:0]                  ret_tag;

  assign starve_hit = (cnt_q == CNT_MAX);
  assign ret_tag    = tag_pipe_q[MEM_LAT-1];

  // Fixed-priority grant: r0, then promoted r2, then blanking round-robin.
  always_comb begin
    r0_gnt = 1'b0;
    r1_gnt = 1'b0;
    r2_gnt = 1'b0;
    if (r0_req) begin
      r0_gnt = 1'b1;
    end else if (starve_hit && r2_req) begin
      r2_gnt = 1'b1;
    end else if (!video_on) begin
      // During active video the slot stays with r0 even when it is idle.
      if (r1_req && r2_req) begin
        if (rr_q == RR_R1) r1_gnt = 1'b1;
        else               r2_gnt = 1'b1;
      end else if (r1_req) begin
        r1_gnt = 1'b1;
      end else if (r2_req) begin
        r2_gnt = 1'b1;
      end
    end
  end

  // Issue stage, round-robin pointer and r2 starvation counter.
  always_comb begin
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    mem_en_d  = 1'b0;
    mem_x_d   = mem_x_q;
    mem_y_d   = mem_y_q;
    tag_d     = TAG_NONE;

    if (r0_gnt) begin
      mem_en_d = 1'b1;
      mem_x_d  = r0_x;
      mem_y_d  = r0_y;
      tag_d    = TAG_R0;
    end else if (r1_gnt) begin
      mem_en_d = 1'b1;
      mem_x_d  = r1_x;
      mem_y_d  = r1_y;
      tag_d    = TAG_R1;
    end else if (r2_gnt) begin
      mem_en_d = 1'b1;
      mem_x_d  = r2_x;
      mem_y_d  = r2_y;
      tag_d    = TAG_R2;
    end

    // Any grant to r1 or r2 (including a promotion) hands the tie to the other.
    if (r1_gnt)      rr_d = RR_R2;
    else if (r2_gnt) rr_d = RR_R1;

    if (r2_req && !r2_gnt) begin
      cnt_d = starve_hit ? cnt_q : cnt_q + CNT_W'(1);
    end else begin
      cnt_d = '0;
    end
    // Registered from the next count so the flag lines up with the counter.
    starved_d = (cnt_d == CNT_MAX);
  end

  // Tag delay line: one stage per cycle of memory latency.
  always_comb begin
    tag_pipe_d    = tag_pipe_q;
    tag_pipe_d[0] = tag_q;
    for (int k = 1; k < MEM_LAT; k++) begin
      tag_pipe_d[k] = tag_pipe_q[k-1];
    end
  end

  // Return routing: the tag leaving the delay line selects the owner.
  always_comb begin
    r0_valid  = (ret_tag == TAG_R0);
    r1_valid  = (ret_tag == TAG_R1);
    r2_valid  = (ret_tag == TAG_R2);
    r0_data   = r0_valid ? mem_data : r0_hold_q;
    r1_data   = r1_valid ? mem_data : r1_hold_q;
    r2_data   = r2_valid ? mem_data : r2_hold_q;
    r0_hold_d = r0_data;
    r1_hold_d = r1_data;
    r2_hold_d = r2_data;
  end

  // State registers; reset drops everything in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q       <= RR_R1;
      cnt_q      <= '0;
      starved_q  <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_x_q    <= '0;
      mem_y_q    <= '0;
      tag_q      <= TAG_NONE;
      tag_pipe_q <= '0;
      r0_hold_q  <= 1'b0;
      r1_hold_q  <= 1'b0;
      r2_hold_q  <= 1'b0;
    end else begin
      rr_q       <= rr_d;
      cnt_q      <= cnt_d;
      starved_q  <= starved_d;
      mem_en_q   <= mem_en_d;
      mem_x_q    <= mem_x_d;
      mem_y_q    <= mem_y_d;
      tag_q      <= tag_d;
      tag_pipe_q <= tag_pipe_d;
      r0_hold_q  <= r0_hold_d;
      r1_hold_q  <= r1_hold_d;
      r2_hold_q  <= r2_hold_d;
    end
  end

  assign mem_en     = mem_en_q;
  assign mem_x      = mem_x_q;
  assign mem_y      = mem_y_q;
  assign r2_starved = starved_q;

endmodule

// File: tb/tb_tile_mem_arbiter.sv
// Bench for tile_mem_arbiter: table of grant vectors plus hand sequences
// for round-robin, starvation, r0 blocking, pipelining and mid-traffic reset.
module tb_tile_mem_arbiter;

  localparam int CW   = 10;
  localparam int LAT  = 3;
  localparam int SMAX = 63;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          video_on;
  logic          r0_req, r1_req, r2_req;
  logic [CW-1:0] r0_x, r0_y, r1_x, r1_y, r2_x, r2_y;
  logic          r0_gnt, r1_gnt, r2_gnt;
  logic          r0_valid, r1_valid, r2_valid;
  logic          r0_data, r1_data, r2_data;
  logic          mem_en;
  logic [CW-1:0] mem_x, mem_y;
  logic          mem_data;
  logic          r2_starved;

  tile_mem_arbiter #(.COORD_W(CW), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .rst_n(rst_n), .video_on(video_on),
    .r0_req(r0_req), .r0_x(r0_x), .r0_y(r0_y),
    .r0_gnt(r0_gnt), .r0_valid(r0_valid), .r0_data(r0_data),
    .r1_req(r1_req), .r1_x(r1_x), .r1_y(r1_y),
    .r1_gnt(r1_gnt), .r1_valid(r1_valid), .r1_data(r1_data),
    .r2_req(r2_req), .r2_x(r2_x), .r2_y(r2_y),
    .r2_gnt(r2_gnt), .r2_valid(r2_valid), .r2_data(r2_data),
    .mem_en(mem_en), .mem_x(mem_x), .mem_y(mem_y),
    .mem_data(mem_data), .r2_starved(r2_starved)
  );

  // Clock.
  always #5 clk = ~clk;

  // Memory model: tile bit = x[0]^y[0], returned LAT cycles after mem_en.
  logic mem_line [LAT];
  always @(posedge clk) begin
    mem_line[0] <= mem_en ? (mem_x[0] ^ mem_y[0]) : 1'($urandom_range(0, 1));
    for (int k = 1; k < LAT; k++) mem_line[k] <= mem_line[k-1];
  end
  assign mem_data = mem_line[LAT-1];

  // Scoreboard: {owner one-hot[2:0], data} per issue cycle.
  logic [3:0]    exp_q[$];
  int            checks = 0;
  int            errors = 0;
  logic [2:0]    last_data;
  logic          prev_en;
  logic [CW-1:0] exp_mx, exp_my;
  int            wait_cnt;

  typedef struct {
    logic       vid;
    logic [2:0] req;  // bit0=r0, bit1=r1, bit2=r2
    logic [2:0] gnt;
  } vec_t;
  vec_t vecs[17];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    exp_q.delete();
    last_data = '0;
    prev_en   = 1'b0;
    exp_mx    = '0;
    exp_my    = '0;
    wait_cnt  = 0;
  endtask

  // One clock cycle: drive, check combinational grant and registered
  // outputs, push the expected return, pop and check the due return.
  task automatic step(input logic vid, input logic [2:0] req,
                      input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                      input logic [2:0] exp_gnt);
    logic [CW-1:0] x1, y1, x2, y2;
    logic [3:0]    e;
    logic          ed;
    @(negedge clk);
    x1 = CW'($urandom); y1 = CW'($urandom);
    x2 = CW'($urandom); y2 = CW'($urandom);
    video_on = vid;
    r0_req = req[0]; r1_req = req[1]; r2_req = req[2];
    r0_x = x0; r0_y = y0; r1_x = x1; r1_y = y1; r2_x = x2; r2_y = y2;
    #1;
    chk("gnt", {29'd0, r2_gnt, r1_gnt, r0_gnt}, {29'd0, exp_gnt});
    chk("mem_en", {31'd0, mem_en}, {31'd0, prev_en});
    chk("mem_x", {22'd0, mem_x}, {22'd0, exp_mx});
    chk("mem_y", {22'd0, mem_y}, {22'd0, exp_my});
    chk("r2_starved", {31'd0, r2_starved}, {31'd0, (wait_cnt == SMAX)});

    ed = 1'b0;
    if (exp_gnt[0]) ed = x0[0] ^ y0[0];
    if (exp_gnt[1]) ed = x1[0] ^ y1[0];
    if (exp_gnt[2]) ed = x2[0] ^ y2[0];
    exp_q.push_back({exp_gnt, ed});

    if (exp_q.size() > LAT + 1) begin
      e = exp_q.pop_front();
      chk("valid", {29'd0, r2_valid, r1_valid, r0_valid}, {29'd0, e[3:1]});
      for (int i = 0; i < 3; i++) if (e[i+1]) last_data[i] = e[0];
    end else begin
      chk("valid_idle", {29'd0, r2_valid, r1_valid, r0_valid}, 32'd0);
    end
    chk("data", {29'd0, r2_data, r1_data, r0_data}, {29'd0, last_data});

    prev_en = |exp_gnt;
    if (exp_gnt[0]) begin exp_mx = x0; exp_my = y0; end
    if (exp_gnt[1]) begin exp_mx = x1; exp_my = y1; end
    if (exp_gnt[2]) begin exp_mx = x2; exp_my = y2; end
    if (req[2] && !exp_gnt[2]) wait_cnt = (wait_cnt == SMAX) ? SMAX : wait_cnt + 1;
    else                       wait_cnt = 0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
    chk("rst_mem_xy", {12'd0, mem_x, mem_y}, 32'd0);
    chk("rst_valid", {29'd0, r2_valid, r1_valid, r0_valid}, 32'd0);
    chk("rst_data", {29'd0, r2_data, r1_data, r0_data}, 32'd0);
    chk("rst_starved", {31'd0, r2_starved}, 32'd0);
  endtask

  // Hard bound on the run.
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset
    rst_n = 1'b0; video_on = 1'b0;
    r0_req = 1'b0; r1_req = 1'b0; r2_req = 1'b0;
    r0_x = '0; r0_y = '0; r1_x = '0; r1_y = '0; r2_x = '0; r2_y = '0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;

    // Grant table, starting from pointer=r1 and counter=0.
    vecs[0]  = '{1'b1, 3'b111, 3'b001};
    vecs[1]  = '{1'b1, 3'b110, 3'b000};
    vecs[2]  = '{1'b0, 3'b110, 3'b010};
    vecs[3]  = '{1'b0, 3'b110, 3'b100};
    vecs[4]  = '{1'b0, 3'b100, 3'b100};
    vecs[5]  = '{1'b0, 3'b100, 3'b100};
    vecs[6]  = '{1'b0, 3'b010, 3'b010};
    vecs[7]  = '{1'b0, 3'b010, 3'b010};
    vecs[8]  = '{1'b0, 3'b111, 3'b001};
    vecs[9]  = '{1'b0, 3'b110, 3'b100};
    vecs[10] = '{1'b0, 3'b000, 3'b000};
    vecs[11] = '{1'b1, 3'b000, 3'b000};
    vecs[12] = '{1'b1, 3'b001, 3'b001};
    vecs[13] = '{1'b0, 3'b001, 3'b001};
    vecs[14] = '{1'b0, 3'b110, 3'b010};
    vecs[15] = '{1'b1, 3'b110, 3'b000};
    vecs[16] = '{1'b0, 3'b110, 3'b100};
    for (int i = 0; i < 17; i++)
      step(vecs[i].vid, vecs[i].req, CW'($urandom), CW'($urandom), vecs[i].gnt);

    // Blanking round-robin: r1,r2,r1,r2,r1,r2 (pointer is back at r1).
    for (int i = 0; i < 6; i++)
      step(1'b0, 3'b110, '0, '0, (i % 2 == 0) ? 3'b010 : 3'b100);
    for (int i = 0; i < LAT + 2; i++) step(1'b0, 3'b000, '0, '0, 3'b000);

    // Starvation promotion during active video.
    for (int i = 0; i < SMAX; i++) step(1'b1, 3'b100, '0, '0, 3'b000);
    step(1'b1, 3'b100, '0, '0, 3'b100);
    step(1'b1, 3'b100, '0, '0, 3'b000);
    step(1'b1, 3'b000, '0, '0, 3'b000);

    // r0 requesting continuously blocks promotion.
    for (int i = 0; i < SMAX + 8; i++)
      step(1'b1, 3'b101, CW'($urandom), CW'($urandom), 3'b001);
    step(1'b1, 3'b100, '0, '0, 3'b100);
    step(1'b1, 3'b000, '0, '0, 3'b000);

    // Back-to-back pipeline: x=0..7, y=0 gives data 0,1,0,1,...
    for (int i = 0; i < 8; i++) step(1'b1, 3'b001, CW'(i), '0, 3'b001);
    for (int i = 0; i < LAT + 2; i++) step(1'b1, 3'b000, '0, '0, 3'b000);

    // Coordinate wrap extremes pass through unchanged.
    step(1'b0, 3'b001, '1, '1, 3'b001);
    step(1'b0, 3'b001, '0, '1, 3'b001);

    // Reset mid-traffic with accesses in flight.
    for (int i = 0; i < 4; i++)
      step(1'b1, 3'b001, CW'($urandom), CW'($urandom), 3'b001);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    clear_model();
    for (int i = 0; i < 8; i++)
      step(1'b1, 3'b001, CW'($urandom), CW'($urandom), 3'b001);
    for (int i = 0; i < LAT + 2; i++) step(1'b0, 3'b000, '0, '0, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tile_mem_arbiter.md
Name: tile_mem_arbiter

Overview:
- Shares the single-port platform/bar tile memory between three requesters:
  - r0: map pixel renderer
  - r1: ladder/prop renderer
  - r2: sprite-vs-platform collision checker
- Sits between the VGA draw path and the tile memory.
- Issues one registered memory access per cycle and routes the returned tile bit back to the requester that owned that access, with fixed latency.
- Guarantees the pixel renderer never loses a slot during active video. Collision lookups are still serviced through starvation promotion.

Parameters:
- COORD_W, 10, width of the x and y tile-memory coordinates.
- MEM_LAT, 1, cycles from mem_en to valid mem_data (range 1..4).
- STARVE_MAX, 63, wait cycles before r2 is promoted above r1.

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous active-low reset
- video_on  in  1  high during active display area
- r0_req  in  1  renderer request (level, held until granted)
- r0_x, r0_y  in  COORD_W each  renderer tile-relative coordinates
- r0_gnt  out  1  combinational grant to r0
- r0_valid  out  1  r0 read data valid pulse
- r0_data  out  1  tile bit for r0
- r1_req, r1_x, r1_y, r1_gnt, r1_valid, r1_data  same widths and meaning as the r0 signals, for the ladder/prop renderer
- r2_req, r2_x, r2_y, r2_gnt, r2_valid, r2_data  same widths and meaning as the r0 signals, for the collision checker
- mem_en  out  1  registered memory access strobe
- mem_x, mem_y  out  COORD_W each  registered memory coordinates
- mem_data  in  1  memory read bit, valid MEM_LAT cycles after mem_en
- r2_starved  out  1  high while the r2 wait counter is saturated

Behaviour:
- Reset (asynchronous, rst_n=0): mem_en=0, mem_x=mem_y=0, all rN_valid=0, all rN_data=0, wait counter=0, round-robin pointer=r1, r2_starved=0, in-flight tag pipeline cleared. Accesses in flight when reset asserts produce no valid pulse.
- Grants are combinational from the current-cycle req and state. At most one rN_gnt is high per cycle. A gnt is issued only when the matching req is high.
- Grant priority, applied in order:
  - r0_req=1: grant r0, regardless of video_on.
  - Else if r2 wait counter == STARVE_MAX and r2_req=1: grant r2.
  - Else if video_on=1: grant neither r1 nor r2. r0 owns the slot even when idle, which keeps renderer timing deterministic.
  - Else (blanking): round-robin between r1 and r2, starting from the pointer. After each grant to r1 or r2 the pointer moves to the other requester. A lone requester is granted every cycle.
- Issue: in the grant cycle t, the granted coordinates and a 2-bit owner tag are registered. At t+1: mem_en=1 and mem_x/mem_y hold the coordinates. With no grant, mem_en=0 at t+1 and mem_x/mem_y hold their previous values.
- Return: the tag is delayed MEM_LAT cycles alongside mem_en. At t+1+MEM_LAT the owner gets rN_valid=1 for one cycle with rN_data=mem_data. All other rN_valid=0. Every rN_data holds its last value between pulses.
- Pipelining: a new grant is legal every cycle; tags never collide. A requester holding req high after gnt is treated as a new request and may be granted again next cycle.
- Wait counter (r2):
  - Increments each cycle r2_req=1 and r2_gnt=0, saturating at STARVE_MAX.
  - Clears to 0 on r2_gnt=1 or on r2_req=0.
  - r2_starved = (counter == STARVE_MAX), registered.
- Starvation limit: promotion never pre-empts r0. If r0 requests continuously, r2 stays starved and r2_starved stays high.
- Coordinates pass through unmodified. There is no bounds clipping; COORD_W-bit values wrap as supplied.
- video_on may toggle in any cycle. Its effect on grants is immediate (same-cycle combinational). In-flight returns are unaffected.

Test Plan:
- Reset mid-traffic: r0 requesting every cycle, MEM_LAT=2; deassert rst_n one cycle after mem_en -> all outputs 0 immediately; no r0_valid after release until a new grant plus 3 cycles.
- Active video priority: video_on=1; r0_req=1 with (x,y)=(5,0); r1_req=r2_req=1 -> only r0_gnt; mem_en=1 with mem_x=5 next cycle; r0_valid=1 with mem_data at t+1+MEM_LAT; r1_valid=r2_valid=0 throughout.
- Blanking round-robin: video_on=0, r0_req=0, r1_req=r2_req=1 held for 6 cycles -> grants r1,r2,r1,r2,r1,r2; valids return in the same order, MEM_LAT+1 cycles later.
- Starvation promotion: STARVE_MAX=63, video_on=1, r0_req=0, r2_req=1 -> r2_starved=1 after 63 waiting cycles; r2_gnt on the next cycle; counter cleared; r2_starved=0 the cycle after.
- Back-to-back pipeline: MEM_LAT=3; memory model returns mem_data = x[0] for the registered x; r0 issues x=0..7 on consecutive cycles -> r0_valid high 8 consecutive cycles with r0_data pattern 0,1,0,1,0,1,0,1.
- r0 blocks promotion: r0_req=1 continuously, r2_req=1 -> r2 never granted; r2_starved stays 1; r2 granted the first cycle r0_req drops.
